// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for the bit-serial ALU sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_NOR);
    endfunction

    function automatic logic op_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; the carry chain is evaluated for every opcode.
module alu_bit_slice
    import alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       CarryIn,
    input  logic [3:0] ALUOp,
    output logic       Result,
    output logic       CarryOut
);

    logic b_eff;
    logic sum;

    always_comb begin
        b_eff    = (ALUOp == OP_SUB) ? ~b : b;
        sum      = a ^ b_eff ^ CarryIn;
        CarryOut = (a & b_eff) | (CarryIn & (a ^ b_eff));
        Result   = 1'b0;
        case (ALUOp)
            OP_AND:         Result = a & b;
            OP_OR:          Result = a | b;
            OP_ADD, OP_SUB: Result = sum;
            OP_NOR:         Result = ~(a | b);
            default:        Result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one slice evaluation per clock, LSB first, start/busy/done handshake.
// Optional overflow output is enabled with `define ALU_SEQ_OVERFLOW_EN.
module alu_serial_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
`ifdef ALU_SEQ_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0] result_nxt;
    logic [3:0]       op;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             slice_res, slice_cout;
    logic             accept, last;

    alu_bit_slice u_slice (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .CarryIn  (carry),
        .ALUOp    (op),
        .Result   (slice_res),
        .CarryOut (slice_cout)
    );

    assign result_nxt = {slice_res, result[WIDTH-1:1]};

    // Next-state: DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_d = op_legal(ALUOp) ? RUN : DONE;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            op        <= OP_AND;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef ALU_SEQ_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            state <= state_d;
            busy  <= (state_d == RUN);
            done  <= (state_d == DONE);
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                op    <= ALUOp;
                carry <= (ALUOp == OP_SUB);
                cnt   <= '0;
                err   <= ~op_legal(ALUOp);
                // Illegal opcodes complete immediately with a fixed zero result.
                if (!op_legal(ALUOp)) begin
                    result    <= '0;
                    carry_out <= 1'b0;
                    zero      <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
                    overflow  <= 1'b0;
`endif
                end
            end else if (state == RUN) begin
                result <= result_nxt;
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                carry  <= slice_cout;
                if (last) begin
                    carry_out <= op_arith(op) & slice_cout;
                    zero      <= (result_nxt == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                    overflow  <= op_arith(op) & (carry ^ slice_cout);
`endif
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=8): directed steps, result scoreboard popped on done.
module tb_alu_serial_seq;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zr;
        logic         er;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   ALUOp = 4'b0000;
    logic         busy, done, carry_out, zero, err;
    logic [W-1:0] result;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int done_seen = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ALUOp     (ALUOp),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
`ifdef ALU_SEQ_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .err       (err)
    );

`ifndef ALU_SEQ_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0] s;
        logic [W-1:0] yy;
        e.cout = 1'b0;
        e.er   = 1'b0;
        e.ovf  = 1'b0;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b1100: e.res = ~(x | y);
            4'b0010, 4'b0110: begin
                yy = (op == 4'b0110) ? ~y : y;
                s = {1'b0, x} + {1'b0, yy} + ((op == 4'b0110) ? 9'd1 : 9'd0);
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (x[W-1] == yy[W-1]) && (e.res[W-1] != x[W-1]);
            end
            default: begin
                e.res = '0;
                e.er  = 1'b1;
            end
        endcase
        e.zr = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_seen++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done observed=1 expected=0");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_carry_out", 32'(carry_out), 32'(e.cout));
                check("sb_zero", 32'(zero), 32'(e.zr));
                check("sb_err", 32'(err), 32'(e.er));
`ifdef ALU_SEQ_OVERFLOW_EN
                check("sb_overflow", 32'(overflow), 32'(e.ovf));
`endif
            end
        end
    end

    // Issue one op from the current cycle and count edges until done.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int exp_lat);
        int n;
        start = 1'b1;
        ALUOp = op;
        a = x;
        b = y;
        sb.push_back(model(op, x, y));
        tick();
        start = 1'b0;
        a = ~x;
        b = ~y;
        n = 1;
        check("busy_after_accept", 32'(busy), 32'(exp_lat > 1));
        while (!done && n < 30) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int n;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        run_op(4'b0010, 8'h7F, 8'h01, 9);
        tick();
        tick();
        run_op(4'b0110, 8'h05, 8'h05, 9);
        run_op(4'b0110, 8'h03, 8'h05, 9);
        tick();

        // Back-to-back: each start issued in the DONE cycle of the previous op.
        run_op(4'b0000, 8'hF0, 8'h3C, 9);
        run_op(4'b0001, 8'hF0, 8'h3C, 9);
        run_op(4'b1100, 8'hF0, 8'h3C, 9);
        run_op(4'b0011, 8'hAA, 8'h55, 1);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("err_held", 32'(err), 32'd1);
        tick();

        // Start pulsed mid-operation must be ignored.
        start = 1'b1;
        ALUOp = 4'b0010;
        a = 8'h12;
        b = 8'h34;
        sb.push_back(model(4'b0010, 8'h12, 8'h34));
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        ALUOp = 4'b0110;
        a = 8'hFF;
        b = 8'hFF;
        tick();
        start = 1'b0;
        n = 5;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        check("ignored_start_latency", 32'(n), 32'd9);
        tick();

        // Reset during an operation aborts it with no done pulse.
        done_seen = 0;
        start = 1'b1;
        ALUOp = 4'b0010;
        a = 8'h11;
        b = 8'h22;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Recovery plus full-width carry out and zero.
        run_op(4'b0010, 8'hFF, 8'h01, 9);
        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
